// File: rtl/adc_capture.sv
// rtl/adc_capture.sv - SPI ADC sampler that DMA-writes sign-extended samples into RAM
// Halts after SAMPLE_AMNT samples or wraps as a ring buffer; includes its SPI read-only master.

module spi_master_ss_no_write #(
   parameter int WID               = 18,
   parameter int WID_SIZ           = 5,
   parameter int POLARITY          = 0,
   parameter int PHASE             = 1,
   parameter int CYCLE_HALF_WAIT   = 10,
   parameter int TIMER_LEN         = 4,
   parameter int SS_WAIT           = 5,
   parameter int SS_WAIT_TIMER_LEN = 3
) (
   input  logic           clk,
   input  logic           rst_L,
   input  logic           arm,
   input  logic           miso,
   output logic [WID-1:0] from_slave,
   output logic           finished,
   output logic           sck,
   output logic           ss_L
);
   localparam int   TW       = (TIMER_LEN > SS_WAIT_TIMER_LEN) ? TIMER_LEN : SS_WAIT_TIMER_LEN;
   localparam logic IDLE_SCK = (POLARITY != 0);

   typedef enum logic [2:0] {SP_IDLE, SP_SETUP, SP_LEAD, SP_TRAIL, SP_HOLD, SP_DONE} sp_state_t;
   sp_state_t state, state_nxt;

   logic [TW-1:0]      timer;
   logic [WID_SIZ-1:0] bit_cnt;
   logic               half_done, ss_done, last_bit, sample_now;

   assign half_done  = (timer == TW'(CYCLE_HALF_WAIT - 1));
   assign ss_done    = (timer == TW'(SS_WAIT - 1));
   assign last_bit   = (bit_cnt == WID_SIZ'(WID - 1));
   // Mode 1 samples on the trailing SCK edge, mode 0 on the leading one
   assign sample_now = half_done && ((PHASE != 0) ? (state == SP_TRAIL) : (state == SP_LEAD));
   assign finished   = (state == SP_DONE);

   always_comb begin
      state_nxt = state;
      case (state)
         SP_IDLE:  if (arm) state_nxt = SP_SETUP;
         SP_SETUP: if (ss_done) state_nxt = SP_LEAD;
         SP_LEAD:  if (half_done) state_nxt = SP_TRAIL;
         SP_TRAIL: if (half_done) state_nxt = last_bit ? SP_HOLD : SP_LEAD;
         SP_HOLD:  if (ss_done) state_nxt = SP_DONE;
         SP_DONE:  if (!arm) state_nxt = SP_IDLE;
         default:  state_nxt = SP_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_L) begin
      if (!rst_L) begin
         state      <= SP_IDLE;
         timer      <= '0;
         bit_cnt    <= '0;
         from_slave <= '0;
         sck        <= IDLE_SCK;
         ss_L       <= 1'b1;
      end else begin
         state <= state_nxt;
         timer <= (state_nxt != state) ? '0 : timer + 1'b1;
         if (state == SP_IDLE)
            bit_cnt <= '0;
         else if (state == SP_TRAIL && half_done)
            bit_cnt <= bit_cnt + 1'b1;
         if (sample_now)
            from_slave <= {from_slave[WID-2:0], miso};
         sck  <= (state_nxt == SP_TRAIL) ? !IDLE_SCK : IDLE_SCK;
         ss_L <= (state_nxt == SP_IDLE) || (state_nxt == SP_DONE);
      end
   end
endmodule

module adc_capture #(
   parameter int ADC_WID                 = 18,
   parameter int ADC_WID_SIZ             = 5,
   parameter int ADC_POLARITY            = 0,
   parameter int ADC_PHASE               = 1,
   parameter int ADC_CYCLE_HALF_WAIT     = 10,
   parameter int ADC_CYCLE_HALF_WAIT_SIZ = 4,
   parameter int ADC_SS_WAIT             = 5,
   parameter int ADC_SS_WAIT_SIZ         = 3,
   parameter int TIMER_WID               = 32,
   parameter int SAMPLE_AMNT_WID         = 11,
   parameter int SAMPLE_AMNT             = 2047,
   parameter int RAM_WID                 = 32,
   parameter int RAM_WORD_WID            = 16,
   parameter int RAM_WORD_INCR           = 2
) (
   input  logic                       clk,
   input  logic                       rst_L,
   input  logic                       arm,
   input  logic                       halt_on_finish,
   input  logic [TIMER_WID-1:0]       time_to_wait,
   input  logic [RAM_WID-1:0]         start_addr,
   output logic                       finished,
   output logic                       running,
   output logic                       wrapped,
   output logic [SAMPLE_AMNT_WID-1:0] sample_cnt,
   output logic [RAM_WID-1:0]         ram_dma_addr,
   output logic [RAM_WORD_WID-1:0]    ram_word,
   output logic                       ram_write,
   input  logic                       ram_valid,
   input  logic                       miso,
   output logic                       sck,
   output logic                       ss_L
);
   localparam int SW = 2 * RAM_WORD_WID;

   typedef enum logic [2:0] {
      IDLE, DO_WAIT, ADC_READ, WRITE_LO, WRITE_HI, END_CHECK, WAIT_ON_DISARM
   } state_t;
   state_t state, state_nxt;

   logic [RAM_WID-1:0]   base, addr;
   logic [TIMER_WID-1:0] wait_timer;
   logic [SW-1:0]        sample;
   logic [ADC_WID-1:0]   adc_data;
   logic                 adc_arm, adc_finished, accepted, buf_full;

   spi_master_ss_no_write #(
      .WID(ADC_WID), .WID_SIZ(ADC_WID_SIZ), .POLARITY(ADC_POLARITY), .PHASE(ADC_PHASE),
      .CYCLE_HALF_WAIT(ADC_CYCLE_HALF_WAIT), .TIMER_LEN(ADC_CYCLE_HALF_WAIT_SIZ),
      .SS_WAIT(ADC_SS_WAIT), .SS_WAIT_TIMER_LEN(ADC_SS_WAIT_SIZ)
   ) u_spi (
      .clk(clk), .rst_L(rst_L), .arm(adc_arm), .miso(miso),
      .from_slave(adc_data), .finished(adc_finished), .sck(sck), .ss_L(ss_L)
   );

   // A stray ram_valid while no request is outstanding is ignored
   assign accepted = ram_write && ram_valid;
   assign buf_full = (sample_cnt == SAMPLE_AMNT_WID'(SAMPLE_AMNT));
   assign running  = (state != IDLE);

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:      if (arm) state_nxt = DO_WAIT;
         DO_WAIT:   if (!arm) state_nxt = IDLE;
                    else if (wait_timer == '0) state_nxt = ADC_READ;
         ADC_READ:  if (adc_finished) state_nxt = WRITE_LO;
         WRITE_LO:  if (accepted) state_nxt = WRITE_HI;
         WRITE_HI:  if (accepted) state_nxt = END_CHECK;
         END_CHECK: if (buf_full) state_nxt = halt_on_finish ? WAIT_ON_DISARM : DO_WAIT;
                    else state_nxt = arm ? DO_WAIT : IDLE;
         WAIT_ON_DISARM: if (!arm) state_nxt = IDLE;
         default:   state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_L) begin
      if (!rst_L) state <= IDLE;
      else        state <= state_nxt;
   end

   always_ff @(posedge clk or negedge rst_L) begin
      if (!rst_L) begin
         finished     <= 1'b0;
         wrapped      <= 1'b0;
         ram_write    <= 1'b0;
         adc_arm      <= 1'b0;
         sample_cnt   <= '0;
         ram_dma_addr <= '0;
         ram_word     <= '0;
         wait_timer   <= '0;
         base         <= '0;
         addr         <= '0;
         sample       <= '0;
      end else begin
         case (state)
            IDLE: begin
               finished <= 1'b0;
               if (arm) begin
                  base       <= start_addr;
                  addr       <= start_addr;
                  sample_cnt <= '0;
                  wrapped    <= 1'b0;
                  wait_timer <= time_to_wait;
               end
            end
            DO_WAIT:
               if (arm) begin
                  if (wait_timer == '0) adc_arm <= 1'b1;
                  else                  wait_timer <= wait_timer - 1'b1;
               end
            ADC_READ:
               if (adc_finished) begin
                  sample  <= SW'($signed(adc_data));
                  adc_arm <= 1'b0;
               end
            // Request is raised one cycle after entry, which gives the gap between words
            WRITE_LO, WRITE_HI:
               if (accepted) begin
                  ram_write <= 1'b0;
                  addr      <= addr + RAM_WID'(RAM_WORD_INCR);
                  if (state == WRITE_HI) sample_cnt <= sample_cnt + 1'b1;
               end else begin
                  ram_write    <= 1'b1;
                  ram_dma_addr <= addr;
                  ram_word     <= (state == WRITE_LO) ? sample[RAM_WORD_WID-1:0]
                                                      : sample[SW-1:RAM_WORD_WID];
               end
            END_CHECK:
               if (buf_full) begin
                  if (halt_on_finish) begin
                     finished <= 1'b1;
                  end else begin
                     addr       <= base;
                     sample_cnt <= '0;
                     wrapped    <= 1'b1;
                     wait_timer <= time_to_wait;
                  end
               end else if (arm) begin
                  wait_timer <= time_to_wait;
               end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_adc_capture.sv
// tb/tb_adc_capture.sv - scoreboard bench for adc_capture with an SPI ADC model and DMA responder

module tb_adc_capture;
   localparam int ADC_WID = 18;
   localparam int AMNT    = 4;

   logic        clk = 1'b0, rst_L = 1'b0, arm = 1'b0, halt_on_finish = 1'b0;
   logic        ram_valid = 1'b0, miso = 1'b0;
   logic [31:0] time_to_wait = '0, start_addr = '0;
   logic        finished, running, wrapped, ram_write, sck, ss_L;
   logic [10:0] sample_cnt;
   logic [31:0] ram_dma_addr;
   logic [15:0] ram_word;

   adc_capture #(
      .ADC_CYCLE_HALF_WAIT(3), .ADC_CYCLE_HALF_WAIT_SIZ(4),
      .ADC_SS_WAIT(2), .ADC_SS_WAIT_SIZ(3), .SAMPLE_AMNT(AMNT)
   ) dut (
      .clk(clk), .rst_L(rst_L), .arm(arm), .halt_on_finish(halt_on_finish),
      .time_to_wait(time_to_wait), .start_addr(start_addr), .finished(finished),
      .running(running), .wrapped(wrapped), .sample_cnt(sample_cnt),
      .ram_dma_addr(ram_dma_addr), .ram_word(ram_word), .ram_write(ram_write),
      .ram_valid(ram_valid), .miso(miso), .sck(sck), .ss_L(ss_L)
   );

   always #5 clk = ~clk;

   int n_checks = 0, n_pass = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
   endtask

   typedef struct {logic [31:0] addr; logic [15:0] word;} wr_t;
   wr_t         exp_q[$];
   logic [17:0] force_q[$];
   logic [31:0] m_base = '0;
   int unsigned m_n = 0;
   int          frames = 0, writes = 0;
   logic [31:0] last_addr = '0;

   // Reference: sample n lands at base + 4*(n mod AMNT), low half first, value sign-extended
   function automatic void push_expected(input logic [17:0] v);
      longint      s;
      logic [31:0] w;
      wr_t         e;
      s = (v >= 18'h20000) ? longint'(v) - 262144 : longint'(v);
      w = 32'(s);
      e.addr = m_base + 32'(4 * (m_n % AMNT));
      e.word = w[15:0];
      exp_q.push_back(e);
      e.addr = e.addr + 32'd2;
      e.word = w[31:16];
      exp_q.push_back(e);
      m_n++;
   endfunction

   logic [17:0] cur_val = '0;
   int          bit_idx = 0;

   always @(negedge ss_L) begin
      if (rst_L) begin
         frames++;
         if (force_q.size() > 0) cur_val = force_q.pop_front();
         else                    cur_val = 18'($urandom);
         push_expected(cur_val);
         bit_idx = ADC_WID - 1;
      end
   end

   always @(posedge sck) begin
      if (!ss_L && bit_idx >= 0) begin
         miso = cur_val[bit_idx];
         bit_idx--;
      end
   end

   bit          busy = 0, stall = 0, force7 = 0, unstable = 0, expect_gap = 0;
   int          wait_n = 0, delay = 0;
   logic [31:0] lat_a = '0;
   logic [15:0] lat_w = '0;
   wr_t         e_pop;

   always @(negedge clk) begin
      ram_valid = 1'b0;
      if (expect_gap) begin
         check("wr_gap", ram_write, 1'b0);
         expect_gap = 0;
      end
      if (rst_L && ram_write) begin
         if (!busy) begin
            busy = 1; lat_a = ram_dma_addr; lat_w = ram_word; wait_n = 0; unstable = 0;
            delay = force7 ? 7 : int'($urandom_range(0, 3));
         end else if (ram_dma_addr !== lat_a || ram_word !== lat_w) begin
            unstable = 1;
         end
         if (!stall) begin
            if (wait_n == delay) begin
               ram_valid = 1'b1; busy = 0; writes++; last_addr = lat_a; expect_gap = 1;
               if (exp_q.size() == 0) begin
                  n_checks++;
                  $display("FAIL unexpected_write: got addr 0x%0h word 0x%0h expected none", lat_a, lat_w);
               end else begin
                  e_pop = exp_q.pop_front();
                  check("wr_addr", lat_a, e_pop.addr);
                  check("wr_word", lat_w, e_pop.word);
               end
               check("wr_stable", unstable, 1'b0);
            end else begin
               wait_n++;
            end
         end
      end else begin
         busy = 0;
      end
   end

   task automatic start_run(input logic [31:0] a, input bit h, input logic [31:0] t);
      @(negedge clk);
      m_base = a; m_n = 0;
      start_addr = a; halt_on_finish = h; time_to_wait = t; arm = 1'b1;
   endtask

   task automatic wait_finished(input string name);
      int n = 0;
      while (!finished && n < 20000) begin @(negedge clk); n++; end
      if (!finished) begin n_checks++; $display("FAIL %s: timeout waiting for finished", name); end
   endtask

   task automatic disarm_to_idle(input string name);
      int n = 0;
      arm = 1'b0;
      while (running && n < 5000) begin @(negedge clk); n++; end
      repeat (2) @(negedge clk);
      check({name, "_idle"}, {running, finished}, 2'b00);
   endtask

   int f0, w0, n;

   initial begin
      repeat (3) @(posedge clk);
      #1;
      check("rst_running", running, 1'b0);
      check("rst_finished", finished, 1'b0);
      check("rst_wrapped", wrapped, 1'b0);
      check("rst_sample_cnt", sample_cnt, 11'd0);
      check("rst_ram_write", ram_write, 1'b0);
      check("rst_addr", ram_dma_addr, 32'd0);
      check("rst_word", ram_word, 16'd0);
      check("rst_ss", ss_L, 1'b1);
      @(negedge clk) rst_L = 1'b1;

      // Halt mode, 4 samples, sign-extension corner values first
      force_q.push_back(18'h1FFFF);
      force_q.push_back(18'h20000);
      f0 = frames; w0 = writes;
      start_run(32'h1000, 1'b1, 32'd3);
      @(negedge clk) start_addr = 32'hDEAD_0000;
      wait_finished("halt");
      check("halt_writes", writes - w0, 8);
      check("halt_last_addr", last_addr, 32'h100E);
      check("halt_sample_cnt", sample_cnt, 11'd4);
      check("halt_running", running, 1'b1);
      repeat (200) @(negedge clk);
      check("halt_no_more_frames", frames - f0, 4);
      check("halt_finished_held", finished, 1'b1);
      disarm_to_idle("halt");

      // Ring mode with slow DMA acceptance
      force7 = 1;
      f0 = frames; w0 = writes;
      start_run(32'h1000, 1'b0, 32'd20);
      n = 0;
      while (writes - w0 < 10 && n < 20000) begin @(negedge clk); n++; end
      check("ring_ten_writes", writes - w0, 10);
      repeat (3) @(negedge clk);
      check("ring_wrapped", wrapped, 1'b1);
      check("ring_sample_cnt", sample_cnt, 11'd1);
      check("ring_last_addr", last_addr, 32'h1002);
      arm = 1'b0;
      @(negedge clk);
      check("ring_disarm_idle", running, 1'b0);
      check("ring_frames", frames - f0, 5);
      force7 = 0;

      // Disarm during a long wait: no conversion, no write
      f0 = frames; w0 = writes;
      start_run(32'h2000, 1'b1, 32'd100);
      repeat (10) @(negedge clk);
      arm = 1'b0;
      @(negedge clk);
      check("wait_disarm_idle", running, 1'b0);
      repeat (200) @(negedge clk);
      check("wait_disarm_frames", frames - f0, 0);
      check("wait_disarm_writes", writes - w0, 0);

      // Re-arm, back-to-back conversions
      start_run(32'h2000, 1'b1, 32'd0);
      wait_finished("rearm");
      check("rearm_writes", writes - w0, 8);
      check("rearm_last_addr", last_addr, 32'h200E);
      disarm_to_idle("rearm");

      // Asynchronous reset while a low-word write is outstanding
      stall = 1;
      start_run(32'h4000, 1'b0, 32'd2);
      n = 0;
      while (!ram_write && n < 5000) begin @(negedge clk); n++; end
      check("rst_mid_write_req", ram_write, 1'b1);
      repeat (2) @(negedge clk);
      #2 rst_L = 1'b0;
      #1;
      check("rst_mid_ram_write", ram_write, 1'b0);
      check("rst_mid_running", running, 1'b0);
      check("rst_mid_addr", ram_dma_addr, 32'd0);
      check("rst_mid_word", ram_word, 16'd0);
      check("rst_mid_cnt_flags", {sample_cnt, finished, wrapped}, 13'd0);
      arm = 1'b0;
      exp_q.delete();
      stall = 0;
      @(negedge clk) rst_L = 1'b1;
      repeat (5) @(negedge clk);

      check("scoreboard_empty", exp_q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end
endmodule
